// File: rtl/rv64if_pkg.sv
// Shared RV64IF data-side types: address/data widths and the store-buffer entry.
// Doubleword helper drops the byte offset so store/load matching ignores addr[2:0].
package rv64if_pkg;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  function automatic logic [ADDR_W-4:0] dw_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:3];
  endfunction
endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match selector: walks entries oldest to youngest from head so the last hit wins.
// Purely combinational; a valid entry popping this cycle still matches.
module sb_fwd_match
  import rv64if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  sb_entry_t                    ent_i [DEPTH],
  input  logic [DEPTH-1:0]             vld_i,
  input  logic [$clog2(DEPTH)-1:0]     head_i,
  input  logic [ADDR_W-1:0]            addr_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o
);
  localparam int PTR_W = $clog2(DEPTH);

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (vld_i[head_i + PTR_W'(k)] &&
          dw_of(ent_i[head_i + PTR_W'(k)].addr) == dw_of(addr_i)) begin
        hit_o  = 1'b1;
        data_o = ent_i[head_i + PTR_W'(k)].data;
      end
    end
  end
endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write store buffer: stores retire into a DEPTH-entry FIFO and drain over valid/ready;
// loads see memory data unless a pending store to the same doubleword forwards the youngest value.
module dm_store_buffer
  import rv64if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              in_Clk,
  input  logic              in_Rst,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wr_data,
  input  logic              in_wr_en,
  output logic [DATA_W-1:0] out_rd_data,
  output logic              out_stall,
  output logic              out_empty,
  output logic [ADDR_W-1:0] out_mem_rd_addr,
  input  logic [DATA_W-1:0] in_mem_rd_data,
  output logic [ADDR_W-1:0] out_mem_wr_addr,
  output logic [DATA_W-1:0] out_mem_wr_data,
  output logic              out_mem_wr_valid,
  input  logic              in_mem_wr_ready
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  sb_entry_t        ent_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             full, push, pop;
  logic             fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign full      = (count_q == CNT_FULL);
  assign out_stall = in_wr_en && full && !in_mem_wr_ready;
  assign push      = in_wr_en && !out_stall;
  // Reset blocks the write handshake so a drain cannot complete in the reset cycle.
  assign out_mem_wr_valid = (count_q != '0) && !in_Rst;
  assign pop       = out_mem_wr_valid && in_mem_wr_ready;
  assign out_empty = (count_q == '0);

  assign out_mem_wr_addr = ent_q[head_q].addr;
  assign out_mem_wr_data = ent_q[head_q].data;
  assign out_mem_rd_addr = in_addr;

  always_comb begin
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(push);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    vld_d   = vld_q;
    if (pop)  vld_d[head_q] = 1'b0;
    if (push) vld_d[tail_q] = 1'b1;
  end

  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      if (push) ent_q[tail_q] <= '{addr: in_addr, data: in_wr_data};
    end
  end

  sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
    .ent_i  (ent_q),
    .vld_i  (vld_q),
    .head_i (head_q),
    .addr_i (in_addr),
    .hit_o  (fwd_hit),
    .data_o (fwd_data)
  );

  assign out_rd_data = fwd_hit ? fwd_data : in_mem_rd_data;
endmodule
